f1_lights_out: RTL and testbench

Lights-out and reaction-timer block for the F1 start-light game; the receiving end of the light sequencer's delay command. On a rising edge of `cmd_delay` it draws a pseudo-random delay from an internal LFSR and counts that many `en` ticks. It then pulses `time_out` (lights out) and measures the cycles until the player's `react` input. The result is presented on `react_time` with `react_valid`; with the configuration macro enabled, an early press is flagged as a jump start.

---
 rtl/f1_pkg.sv | 18 +
 rtl/lfsr_7.sv | 24 ++
 rtl/f1_lights_out.sv | 135 +++++++++++++
 tb/tb_f1_lights_out.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 lights-out / reaction-timer block.
// Holds the FSM state enum, LFSR tap positions and the default LFSR seed.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REACT,
        DONE
    } lo_state_t;

    // x^7 + x^6 + 1: feedback from bits 6 and 5 of a left-shifting register
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    localparam logic [6:0] DEFAULT_SEED = 7'h01;

endpackage

// File: rtl/lfsr_7.sv
// Free-running maximal-length Fibonacci LFSR, shifting left every clock.
// Ports: clk, rst (async, active-high) in; q = current register state out.
module lfsr_7 import f1_pkg::*; #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    // An all-zero register would lock up, so a zero seed becomes 1
    localparam logic [WIDTH-1:0] INIT = (SEED == '0) ? ONE : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INIT;
        end else begin
            q <= {q[WIDTH-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/f1_lights_out.sv
// Lights-out and reaction timer: random delay on cmd_delay rise, then time_out
// pulse and a measurement of clk cycles until react. Inputs: clk, rst (async,
// active-high), en tick, cmd_delay, react. Outputs: time_out, busy,
// react_valid, react_time, jump_start (early-press detection compiled in only
// when F1_JUMP_START_EN is defined, otherwise tied 0).
module f1_lights_out import f1_pkg::*; #(
    parameter int                    LFSR_WIDTH = 7,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(DEFAULT_SEED),
    parameter int                    RT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cmd_delay,
    input  logic                react,
    output logic                time_out,
    output logic                busy,
    output logic                react_valid,
    output logic [RT_WIDTH-1:0] react_time,
    output logic                jump_start
);

    localparam logic [LFSR_WIDTH-1:0] CNT_ONE = LFSR_WIDTH'(1);
    localparam logic [RT_WIDTH-1:0]   RT_ONE  = RT_WIDTH'(1);

    lo_state_t             state, state_n;
    logic                  cmd_q;
    logic                  rise;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] cnt, cnt_n;
    logic [RT_WIDTH-1:0]   rt_cnt, rt_n;
    logic                  to_n, valid_n;
    logic [RT_WIDTH-1:0]   rtime_n;
`ifdef F1_JUMP_START_EN
    logic                  jump_r, jump_n;
`endif

    lfsr_7 #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign rise = cmd_delay & ~cmd_q;
    assign busy = (state == DELAY) || (state == REACT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rt_n    = rt_cnt;
        to_n    = 1'b0;
        valid_n = react_valid;
        rtime_n = react_time;
`ifdef F1_JUMP_START_EN
        jump_n  = jump_r;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (rise) begin
                    cnt_n   = lfsr;
                    valid_n = 1'b0;
                    rtime_n = '0;
`ifdef F1_JUMP_START_EN
                    jump_n  = 1'b0;
`endif
                    state_n = DELAY;
                end
            end
            DELAY: begin
`ifdef F1_JUMP_START_EN
                // An early press beats a coincident final tick
                if (react) begin
                    jump_n  = 1'b1;
                    state_n = DONE;
                end else if (en) begin
`else
                if (en) begin
`endif
                    cnt_n = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        rt_n    = '0;
                        to_n    = 1'b1;
                        state_n = REACT;
                    end
                end
            end
            REACT: begin
                rt_n = (&rt_cnt) ? rt_cnt : rt_cnt + RT_ONE;
                if (react) begin
                    rtime_n = rt_cnt;
                    valid_n = 1'b1;
                    state_n = DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= 1'b0;
            cnt         <= '0;
            rt_cnt      <= '0;
            time_out    <= 1'b0;
            react_valid <= 1'b0;
            react_time  <= '0;
        end else begin
            state       <= state_n;
            cmd_q       <= cmd_delay;
            cnt         <= cnt_n;
            rt_cnt      <= rt_n;
            time_out    <= to_n;
            react_valid <= valid_n;
            react_time  <= rtime_n;
        end
    end

`ifdef F1_JUMP_START_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_r <= 1'b0;
        end else begin
            jump_r <= jump_n;
        end
    end

    assign jump_start = jump_r;
`else
    assign jump_start = 1'b0;
`endif

endmodule

// File: tb/tb_f1_lights_out.sv
// Self-checking bench for f1_lights_out: directed scenarios plus randomized
// cmd/en/react traffic compared each cycle against a timestamp-based model.
module tb_f1_lights_out;

`ifdef F1_JUMP_START_EN
    localparam bit JS = 1'b1;
`else
    localparam bit JS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, cmd = 1'b0, react = 1'b0;
    logic        time_out, busy, react_valid, jump_start;
    logic [15:0] react_time;

    logic        en2 = 1'b0, cmd2 = 1'b0, react2 = 1'b0;
    logic        to2, busy2, valid2, jump2;
    logic [3:0]  rtime2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f1_lights_out dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cmd_delay   (cmd),
        .react       (react),
        .time_out    (time_out),
        .busy        (busy),
        .react_valid (react_valid),
        .react_time  (react_time),
        .jump_start  (jump_start)
    );

    f1_lights_out #(.RT_WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .en          (en2),
        .cmd_delay   (cmd2),
        .react       (react2),
        .time_out    (to2),
        .busy        (busy2),
        .react_valid (valid2),
        .react_time  (rtime2),
        .jump_start  (jump2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: delay as K counted en ticks from the round start,
    // reaction time as edge distance from the lights-out edge.
    int seq [127];
    int m_idx, m_edge, m_k, m_ticks, m_lo, m_rtime;
    bit m_prev, m_dly, m_rct, m_to, m_valid, m_jump;

    function automatic void build_seq();
        int v;
        v = 1;
        for (int i = 0; i < 127; i++) begin
            seq[i] = v;
            v = ((v << 1) & 'h7F) | (((v >> 6) ^ (v >> 5)) & 1);
        end
    endfunction

    function automatic void model_reset();
        m_idx = 0; m_edge = 0; m_k = 0; m_ticks = 0; m_lo = 0;
        m_rtime = 0; m_prev = 0; m_dly = 0; m_rct = 0;
        m_to = 0; m_valid = 0; m_jump = 0;
    endfunction

    function automatic void model_edge(input bit c, input bit e, input bit r);
        bit rise;
        int d;
        rise = c && !m_prev;
        m_prev = c;
        m_edge++;
        m_to = 0;
        if (m_dly) begin
            if (JS && r) begin
                m_jump = 1;
                m_dly = 0;
            end else if (e) begin
                m_ticks++;
                if (m_ticks == m_k) begin
                    m_dly = 0;
                    m_rct = 1;
                    m_lo = m_edge;
                    m_to = 1;
                end
            end
        end else if (m_rct) begin
            if (r) begin
                d = m_edge - m_lo - 1;
                m_rtime = (d > 65535) ? 65535 : d;
                m_valid = 1;
                m_rct = 0;
            end
        end else if (rise) begin
            m_k = seq[m_idx % 127];
            m_ticks = 0;
            m_valid = 0;
            m_rtime = 0;
            m_jump = 0;
            m_dly = 1;
        end
        m_idx++;
    endfunction

    task automatic step(input logic c, input logic e, input logic r);
        cmd = c; en = e; react = r;
        @(posedge clk);
        model_edge(c, e, r);
        #1;
        chk("time_out", 32'(time_out), 32'(m_to));
        chk("busy", 32'(busy), 32'(m_dly || m_rct));
        chk("react_valid", 32'(react_valid), 32'(m_valid));
        chk("react_time", 32'(react_time), 32'(m_rtime));
        chk("jump_start", 32'(jump_start), 32'(m_jump));
    endtask

    task automatic do_reset();
        cmd = 0; en = 0; react = 0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_time_out", 32'(time_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(react_valid), 32'd0);
        chk("rst_rtime", 32'(react_time), 32'd0);
        chk("rst_jump", 32'(jump_start), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen_to;
        build_seq();
        #2;
        do_reset();

        // K=1: capture on first edge after reset release
        step(1, 1, 0);
        chk("k1_busy", 32'(busy), 32'd1);
        chk("k1_to_early", 32'(time_out), 32'd0);
        step(1, 1, 0);
        chk("k1_to", 32'(time_out), 32'd1);
        step(1, 1, 1);
        chk("k1_to_len", 32'(time_out), 32'd0);
        chk("k1_rtime0", 32'(react_time), 32'd0);
        chk("k1_valid", 32'(react_valid), 32'd1);

        // K=4: capture on third edge, then react 10 cycles later
        do_reset();
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        chk("k4_to_early", 32'(time_out), 32'd0);
        step(1, 1, 0);
        chk("k4_to", 32'(time_out), 32'd1);
        for (int i = 0; i < 10; i++) step(1, 1, 0);
        step(1, 1, 1);
        chk("k4_valid", 32'(react_valid), 32'd1);
        chk("k4_rtime", 32'(react_time), 32'd10);
        for (int i = 0; i < 4; i++) step(1, 1, i[0]);
        chk("k4_hold", 32'(react_time), 32'd10);
        step(0, 1, 0);
        step(1, 1, 0);
        chk("restart_valid", 32'(react_valid), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // Reset mid-DELAY: no time_out afterwards
        for (int i = 0; i < 2; i++) step(1, 1, 0);
        do_reset();
        seen_to = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            seen_to |= time_out;
        end
        chk("rst_no_to", 32'(seen_to), 32'd0);

        // Early press two cycles into a K=4 delay
        do_reset();
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 1);
        seen_to = time_out;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0);
            seen_to |= time_out;
        end
        chk("js_flag", 32'(jump_start), 32'(JS));
        chk("js_to", 32'(seen_to), 32'(!JS));
        chk("js_valid", 32'(react_valid), 32'd0);

        // Random traffic with gapped en and occasional reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic c;
            c = cmd;
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 9) == 0) c = ~cmd;
            step(c, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // RT_WIDTH=4 instance: saturation and ignored edge during REACT
        do_reset();
        cmd2 = 1; en2 = 1; react2 = 0;
        adv();
        chk("w4_busy", 32'(busy2), 32'd1);
        chk("w4_to_early", 32'(to2), 32'd0);
        adv();
        chk("w4_to", 32'(to2), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) cmd2 = 0;
            if (i == 7) cmd2 = 1;
            adv();
        end
        chk("w4_react_busy", 32'(busy2), 32'd1);
        chk("w4_no_to", 32'(to2), 32'd0);
        chk("w4_no_valid", 32'(valid2), 32'd0);
        react2 = 1;
        adv();
        chk("w4_valid", 32'(valid2), 32'd1);
        chk("w4_sat", 32'(rtime2), 32'hF);
        chk("w4_done_busy", 32'(busy2), 32'd0);
        chk("w4_jump", 32'(jump2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
